// File: rtl/train_track_model.sv
// Plant-side model of two trains at a shared crossing: drives the waiting
// sensors, reacts to controller permissions and flags unsafe control.

module train_fsm #(
    parameter int APPROACH_CYC = 4,
    parameter int CROSS_CYC    = 3,
    parameter int CW           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       t,
    output logic       v,
    output logic [1:0] state,
    output logic [7:0] crossings
);

    typedef enum logic [1:0] {
        AWAY    = 2'b00,
        WAITING = 2'b01,
        CROSS   = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    localparam logic [CW-1:0] APP_INIT   = CW'(APPROACH_CYC - 1);
    localparam logic [CW-1:0] CROSS_INIT = CW'(CROSS_CYC - 1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    crossings_q, crossings_d;
    logic          v_q, v_d;

    // Next-state: approach countdown, wait for permission, timed crossing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crossings_d = crossings_q;
        if (run) begin
            case (state_q)
                AWAY: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = WAITING;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                WAITING: begin
                    if (t) begin
                        state_d = CROSS;
                        cnt_d   = CROSS_INIT;
                    end else begin
                        state_d = WAITING;
                    end
                end
                CROSS: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d     = AWAY;
                        cnt_d       = APP_INIT;
                        crossings_d = crossings_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ILLEGAL: begin
                    state_d = AWAY;
                    cnt_d   = APP_INIT;
                end
                default: begin
                    state_d = AWAY;
                    cnt_d   = APP_INIT;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // Sensor is registered alongside the state so it equals (state == WAITING).
        v_d = (state_d == WAITING);
    end

    // Train state register with synchronous reset that aborts any activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= AWAY;
            cnt_q       <= APP_INIT;
            crossings_q <= 8'd0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crossings_q <= crossings_d;
            v_q         <= v_d;
        end
    end

    assign v         = v_q;
    assign state     = state_q;
    assign crossings = crossings_q;

endmodule

module train_track_model #(
    parameter int APPROACH0_CYC = 4,
    parameter int APPROACH1_CYC = 7,
    parameter int CROSS_CYC     = 3,
    parameter int CW            = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       T0,
    input  logic       T1,
    input  logic       B,
    output logic       V0,
    output logic       V1,
    output logic [1:0] state0,
    output logic [1:0] state1,
    output logic [7:0] crossings0,
    output logic [7:0] crossings1,
    output logic       collision,
    output logic       barrier_viol
);

    localparam logic [1:0] CROSS_CODE = 2'b10;

    logic collision_q, collision_d;
    logic barrier_viol_q, barrier_viol_d;
    logic in_cross0_s, in_cross1_s;

    train_fsm #(.APPROACH_CYC(APPROACH0_CYC), .CROSS_CYC(CROSS_CYC), .CW(CW)) u_train0 (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .t         (T0),
        .v         (V0),
        .state     (state0),
        .crossings (crossings0)
    );

    train_fsm #(.APPROACH_CYC(APPROACH1_CYC), .CROSS_CYC(CROSS_CYC), .CW(CW)) u_train1 (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .t         (T1),
        .v         (V1),
        .state     (state1),
        .crossings (crossings1)
    );

    assign in_cross0_s = (state0 == CROSS_CODE);
    assign in_cross1_s = (state1 == CROSS_CODE);

    // Sticky safety flags, judged on the registered train states of this cycle.
    always_comb begin
        collision_d    = collision_q;
        barrier_viol_d = barrier_viol_q;
        if (run) begin
            if (in_cross0_s && in_cross1_s) begin
                collision_d = 1'b1;
            end else begin
                collision_d = collision_q;
            end
            if (B && (in_cross0_s || in_cross1_s)) begin
                barrier_viol_d = 1'b1;
            end else begin
                barrier_viol_d = barrier_viol_q;
            end
        end else begin
            collision_d    = collision_q;
            barrier_viol_d = barrier_viol_q;
        end
    end

    // Flag registers; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            collision_q    <= 1'b0;
            barrier_viol_q <= 1'b0;
        end else begin
            collision_q    <= collision_d;
            barrier_viol_q <= barrier_viol_d;
        end
    end

    assign collision    = collision_q;
    assign barrier_viol = barrier_viol_q;

endmodule
